// File: rtl/seg_pkg.sv
// Shared display-side types and constants for the seven-segment arbiter and its helpers.
package seg_pkg;
  localparam int DIGIT_W = 4;
  localparam int DIGITS  = 6;
  localparam int DISP_W  = DIGIT_W * DIGITS;

  localparam logic [DISP_W-1:0] SEG_BLANK = 24'h0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_SHARE = 2'd2
  } seg_state_t;
endpackage

// File: rtl/ms_tick_gen.sv
// Free-running millisecond prescaler; tick is high for one clk cycle each time the counter wraps.
module ms_tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int DIV = (CLK_HZ / 1000 > 1) ? CLK_HZ / 1000 : 1;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (r_cnt == LAST)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + CW'(1);
  end

  assign tick = (r_cnt == LAST);
endmodule

// File: rtl/seg_disp_arbiter.sv
// Hold-time + round-robin arbiter granting the 6-digit display to one of NREQ requesters.
// Optional requester-0 preemption is enabled by defining SEG_ARB_PREEMPT_EN.
module seg_disp_arbiter
  import seg_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int CLK_HZ  = 50_000_000,
  parameter int HOLD_MS = 500
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DISP_W-1:0] req_data,
  output logic [NREQ-1:0]        gnt,
  output logic [1:0]             owner,
  output logic [DISP_W-1:0]      disp_data,
  output logic                   disp_valid,
  output logic                   hold_done
);
  localparam logic [15:0] HOLD_C = 16'(HOLD_MS);

  seg_state_t        r_state, w_state_nxt;
  logic [1:0]        r_owner, w_owner_nxt;
  logic [15:0]       r_hold, w_hold_nxt;
  logic [DISP_W-1:0] r_disp_data, w_own_data;
  logic              r_disp_valid;
  logic              w_tick, w_own_req, w_preempt;
  logic              w_lo_found, w_rr_found;
  logic [1:0]        w_lo_idx, w_rr_idx;
  int                w_best, w_dist;

  ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_ms_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

`ifdef SEG_ARB_PREEMPT_EN
  assign w_preempt = req[0] && (r_owner != 2'd0);
`else
  assign w_preempt = 1'b0;
`endif

  always_comb begin
    w_own_req  = 1'b0;
    w_own_data = SEG_BLANK;
    for (int i = 0; i < NREQ; i++) begin
      if (r_owner == 2'(i)) begin
        w_own_req  = req[i];
        w_own_data = req_data[DISP_W*i +: DISP_W];
      end
    end
  end

  // Fixed priority from idle: scan downwards so the lowest set index is kept.
  always_comb begin
    w_lo_found = 1'b0;
    w_lo_idx   = 2'd0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_lo_found = 1'b1;
        w_lo_idx   = 2'(i);
      end
    end
  end

  // Round-robin: nearest requester at distance 1..NREQ-1 after the owner.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = r_owner;
    w_best     = NREQ;
    w_dist     = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_dist = (i + NREQ - int'(r_owner)) % NREQ;
      if (req[i] && (w_dist != 0) && (w_dist < w_best)) begin
        w_best     = w_dist;
        w_rr_idx   = 2'(i);
        w_rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_hold_nxt  = r_hold;
    case (r_state)
      ST_IDLE: begin
        if (w_lo_found) begin
          w_state_nxt = ST_OWN;
          w_owner_nxt = w_lo_idx;
          w_hold_nxt  = '0;
        end
      end
      ST_OWN, ST_SHARE: begin
        if (!w_own_req) begin
          w_state_nxt = ST_IDLE;
          w_owner_nxt = 2'd0;
          w_hold_nxt  = '0;
        end else if (w_preempt) begin
          w_state_nxt = ST_OWN;
          w_owner_nxt = 2'd0;
          w_hold_nxt  = '0;
        end else if (r_state == ST_SHARE) begin
          if (w_rr_found) begin
            w_state_nxt = ST_OWN;
            w_owner_nxt = w_rr_idx;
            w_hold_nxt  = '0;
          end
        end else if (r_hold == HOLD_C) begin
          w_state_nxt = ST_SHARE;
        end else if (w_tick) begin
          w_hold_nxt = r_hold + 16'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_owner_nxt = 2'd0;
        w_hold_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_owner <= 2'd0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // Display word follows the registered owner, so it lags the grant by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp_data  <= SEG_BLANK;
      r_disp_valid <= 1'b0;
    end else begin
      r_disp_valid <= (r_state != ST_IDLE);
      if (r_state != ST_IDLE)
        r_disp_data <= w_own_data;
    end
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < NREQ; i++)
      if ((r_state != ST_IDLE) && (r_owner == 2'(i)))
        gnt[i] = 1'b1;
  end

  assign owner      = r_owner;
  assign hold_done  = (r_state == ST_SHARE);
  assign disp_data  = r_disp_data;
  assign disp_valid = r_disp_valid;
endmodule

// File: doc/seg_disp_arbiter.md
# seg_disp_arbiter

Time-shares the 6-digit seven-segment scan driver between up to four requesters, such as a clock counter, an alarm setter and a debug monitor. It arbitrates ownership with a minimum hold time and a round-robin hand-off, then presents one registered 24-bit hex word to the display driver. It sits between the application blocks and the seven-segment scan/decode block.

## Interface
- NREQ, 3: number of requesters, legal range 2..4.
- CLK_HZ, 50_000_000: clk frequency in Hz.
- HOLD_MS, 500: minimum ownership time in milliseconds, legal range 1..65535.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  NREQ  request level per requester; bit i = requester i wants the display.
- req_data  in  NREQ*24  requester i's word is in bits [24*i+23:24*i]; six hex digits, MSB digit leftmost.
- gnt  out  NREQ  one-hot grant; all zero when there is no owner.
- owner  out  2  index of the current owner; 0 when there is no owner.
- disp_data  out  24  word to the display driver.
- disp_valid  out  1  disp_data carries an owner's word.
- hold_done  out  1  the owner's minimum hold time has elapsed.

## Operation
- Millisecond prescaler: a counter runs 0..CLK_HZ/1000-1. An internal tick_ms is high for 1 cycle at the wrap.
- FSM states:
  - IDLE: no owner.
  - OWN: owner is active and the hold is running.
  - SHARE: owner is active and the hold has expired.
- IDLE -> OWN when any req bit is set. The lowest set index wins (fixed priority). The hold counter loads 0.
- OWN:
  - The hold counter increments on each tick_ms.
  - At the count HOLD_MS, go to SHARE and set hold_done=1.
  - Requests from other indices are ignored.
- SHARE: if any other index requests, hand off to the next requesting index in round-robin order starting at owner+1 (mod NREQ). Go to OWN, reload the hold counter to 0 and clear hold_done.
- OWN or SHARE -> IDLE when req[owner] falls. gnt clears on that edge. IDLE lasts at least 1 cycle before the next grant.
- Simultaneous events:
  - Owner drop wins over hand-off and over hold expiry.
  - Hold expiry and a pending request on the same edge: the next edge performs the hand-off.
- Hold counter width is 16 bits and saturates at HOLD_MS.
- The prescaler free-runs and is not restarted by grants. The first millisecond of a hold is therefore 1..CLK_HZ/1000 cycles long.
- disp_data is registered from the req_data slice selected by the registered owner. In IDLE, disp_data holds its last value and disp_valid=0.

## Timing
- Reset values: gnt=0, owner=0, disp_data=24'h0, disp_valid=0, hold_done=0, FSM=IDLE, prescaler=0, hold counter=0.
- Reset is asynchronous and mid-operation: all of the above apply immediately. The first grant occurs no earlier than the 1st clk edge after rst_n rises.
- Latency:
  - req sampled at edge k -> gnt/owner valid after edge k.
  - disp_data/disp_valid valid after edge k+1.
  - req_data changes from the owner appear on disp_data 1 cycle later.
- Release: req[owner] low at edge k -> gnt=0 after edge k, disp_valid=0 after edge k+1.
- No combinational path from req or req_data to any output.

## Configuration
- SEG_ARB_PREEMPT_EN defined:
  - Requester 0 preempts any other owner, in OWN or SHARE, on the edge it asserts req[0].
  - The hold counter reloads.
  - Requester 0 itself can only be displaced by round-robin after its hold expires.
- SEG_ARB_PREEMPT_EN undefined: there is no preemption. The rules in Operation apply unchanged.

## Structure
- Package seg_pkg holds:
  - DIGIT_W=4, DIGITS=6, DISP_W=24.
  - The FSM state enum (ST_IDLE, ST_OWN, ST_SHARE).
  - The blank word constant SEG_BLANK=24'h0.
- Sub-module ms_tick_gen (parameter CLK_HZ; ports clk, rst_n, tick) holds the prescaler. It is reused by other display-side blocks.
- Arbitration and round-robin next-index logic stays inline.

## Test plan
All scenarios use CLK_HZ=4000 (4 cycles per ms) and HOLD_MS=2.
- Reset: assert rst_n low mid-hold with gnt=3'b010 -> gnt=0, disp_valid=0, disp_data=24'h000000 at once, with no clk edge.
- Fixed priority from IDLE: req=3'b110 with data1=24'h123456 -> gnt=3'b010 after 1 edge; disp_data=24'h123456 and disp_valid=1 after 2 edges.
- Hold then round-robin:
  - Owner 1 is held and req=3'b111 throughout.
  - gnt stays 3'b010 until hold_done=1, at 6..9 cycles after the grant.
  - The next edge gives gnt=3'b100 and the following hand-off goes to 3'b001.
- Release: drop req[2] while it is owner -> gnt=0 for exactly 1 cycle, then gnt=3'b001 if req[0]=1. disp_valid shows one low cycle.
- Simultaneous drop and expiry: req[owner] falls on the hold_done edge while req[0]=1 -> IDLE first, no direct hand-off.
- With SEG_ARB_PREEMPT_EN: owner 2 in OWN, req[0] rises at edge k -> gnt=3'b001 after edge k, hold_done=0.
